mcu_shared_ram_arb: RTL and testbench

- Arbitrates the 4 KB MCU/main-CPU shared RAM between two requesters: the main CPU bus and the 8051 MCU external-memory port at 0xCxxx.
- Serialises accesses and generates an MCU stall so the MCU clock enable can be gated while its access is pending.
- Owns the mailbox interrupt `ext_ram_int`: a main-CPU write to the mailbox byte raises it, and an MCU read of the mailbox clears it.
- Sits between the CPU bus decode, the MCU wrapper and a single-port shared RAM.

---
 rtl/mcu_shared_ram_arb.sv | 175 +++++++++++++++++
 tb/tb_mcu_shared_ram_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_shared_ram_arb.sv
// mcu_shared_ram_arb
//   Arbitrates the 4 KB shared RAM between the main CPU bus and the 8051
//   MCU external-memory window. One access at a time, three cycles each:
//   IDLE (grant), ACCESS (RAM driven), COMPLETE (ack, read data valid).
//   Round-robin on ties; after reset the CPU wins the first tie.
//   Also owns the mailbox interrupt: a CPU write to INT_ADDR sets
//   ext_ram_int, and an MCU read of INT_ADDR clears it.
//
//   Optional build macro CPU_POSTED_WRITE_EN: adds a one-entry CPU write
//   buffer. A posted write is acked the cycle after it is seen. The buffer
//   then drains through normal arbitration without a second ack. CPU reads
//   wait behind a full buffer.
//
// Ports
//   CLK_32M, reset          clock, async active-high reset
//   cpu_req/we/addr/dout    CPU request (level, held until cpu_ack)
//   cpu_din, cpu_ack        CPU read data / one-cycle completion pulse
//   mcu_req/we/addr/dout    MCU request (level, held until mcu_ack)
//   mcu_din, mcu_ack        MCU read data / one-cycle completion pulse
//   mcu_stall               mcu_req & ~mcu_ack, gates the MCU clock enable
//   ram_addr/wdata/we       single-port RAM drive
//   ram_rdata               RAM read data, one cycle after ram_addr
//   ext_ram_int             mailbox interrupt to the MCU
module mcu_shared_ram_arb #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] INT_ADDR = 12'hFFF
) (
    input  logic              CLK_32M,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_ack,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [7:0]        mcu_dout,
    output logic [7:0]        mcu_din,
    output logic              mcu_ack,
    output logic              mcu_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              ext_ram_int
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, COMPLETE = 2'd2} state_t;

    state_t            state;
    logic              gnt_cpu;     // current transfer belongs to the CPU side
    logic              gnt_we;      // current transfer is a write
    logic              last_cpu;    // last grant went to the CPU
    logic [7:0]        cpu_din_q;
    logic [7:0]        mcu_din_q;

    // CPU-side request as seen by the arbiter (may be the write buffer)
    logic              cpu_arb_req;
    logic              cpu_sel_we;
    logic [ADDR_W-1:0] cpu_sel_addr;
    logic [7:0]        cpu_sel_data;
    logic              cpu_done_ack;

`ifdef CPU_POSTED_WRITE_EN
    logic              wb_full;
    logic [ADDR_W-1:0] wb_addr;
    logic [7:0]        wb_data;
    logic              post_take;

    // The ~cpu_ack term keeps a write held through its own ack from being posted twice.
    assign post_take    = cpu_req & cpu_we & ~wb_full & ~cpu_ack;
    // A full buffer always goes first, which keeps CPU reads ordered behind it.
    assign cpu_arb_req  = wb_full | (cpu_req & ~cpu_we);
    assign cpu_sel_we   = wb_full;
    assign cpu_sel_addr = wb_full ? wb_addr : cpu_addr;
    assign cpu_sel_data = wb_data;
    // Every granted CPU write is a drain and was already acked when posted.
    assign cpu_done_ack = ~gnt_we;
`else
    assign cpu_arb_req  = cpu_req;
    assign cpu_sel_we   = cpu_we;
    assign cpu_sel_addr = cpu_addr;
    assign cpu_sel_data = cpu_dout;
    assign cpu_done_ack = 1'b1;
`endif

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt_cpu     <= 1'b0;
            gnt_we      <= 1'b0;
            last_cpu    <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= 8'h00;
            ram_we      <= 1'b0;
            cpu_din_q   <= 8'h00;
            mcu_din_q   <= 8'h00;
            cpu_ack     <= 1'b0;
            mcu_ack     <= 1'b0;
            ext_ram_int <= 1'b0;
`ifdef CPU_POSTED_WRITE_EN
            wb_full     <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= 8'h00;
`endif
        end else begin
            ram_we  <= 1'b0;
            cpu_ack <= 1'b0;
            mcu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_arb_req && (!mcu_req || !last_cpu)) begin
                        state     <= ACCESS;
                        gnt_cpu   <= 1'b1;
                        last_cpu  <= 1'b1;
                        gnt_we    <= cpu_sel_we;
                        ram_we    <= cpu_sel_we;
                        ram_addr  <= cpu_sel_addr;
                        ram_wdata <= cpu_sel_data;
                    end else if (mcu_req) begin
                        state     <= ACCESS;
                        gnt_cpu   <= 1'b0;
                        last_cpu  <= 1'b0;
                        gnt_we    <= mcu_we;
                        ram_we    <= mcu_we;
                        ram_addr  <= mcu_addr;
                        ram_wdata <= mcu_dout;
                    end
                end
                ACCESS: begin
                    // Ack and mailbox update land together at the start of COMPLETE.
                    state <= COMPLETE;
                    if (gnt_cpu) begin
                        cpu_ack <= cpu_done_ack;
                        if (gnt_we && ram_addr == INT_ADDR)
                            ext_ram_int <= 1'b1;
`ifdef CPU_POSTED_WRITE_EN
                        if (gnt_we)
                            wb_full <= 1'b0;
`endif
                    end else begin
                        mcu_ack <= 1'b1;
                        if (!gnt_we && ram_addr == INT_ADDR)
                            ext_ram_int <= 1'b0;
                    end
                end
                COMPLETE: begin
                    state <= IDLE;
                    if (!gnt_we) begin
                        if (gnt_cpu) cpu_din_q <= ram_rdata;
                        else         mcu_din_q <= ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef CPU_POSTED_WRITE_EN
            if (post_take) begin
                wb_full <= 1'b1;
                wb_addr <= cpu_addr;
                wb_data <= cpu_dout;
                cpu_ack <= 1'b1;
            end
`endif
        end
    end

    // RAM data only arrives in COMPLETE, the same cycle as the ack. It is
    // passed straight through there and the held copy is used afterwards.
    assign cpu_din   = (state == COMPLETE && gnt_cpu && !gnt_we)  ? ram_rdata : cpu_din_q;
    assign mcu_din   = (state == COMPLETE && !gnt_cpu && !gnt_we) ? ram_rdata : mcu_din_q;
    assign mcu_stall = mcu_req & ~mcu_ack;

endmodule

// File: tb/tb_mcu_shared_ram_arb.sv
// tb_mcu_shared_ram_arb
//   Drives directed and randomized CPU/MCU transactions into
//   mcu_shared_ram_arb backed by a synchronous RAM model. The bench checks
//   ack timing, read data, mcu_stall, ram_we pulses and ext_ram_int against
//   a transaction-level reference model.
module tb_mcu_shared_ram_arb;

    localparam logic [11:0] INT = 12'hFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        mcu_req = 1'b0, mcu_we = 1'b0;
    logic [11:0] mcu_addr = '0;
    logic [7:0]  mcu_dout = '0;
    logic [7:0]  mcu_din;
    logic        mcu_ack, mcu_stall;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = '0;
    logic        ext_ram_int;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mcu_shared_ram_arb #(.ADDR_W(12), .INT_ADDR(INT)) dut (
        .CLK_32M(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
        .mcu_din(mcu_din), .mcu_ack(mcu_ack), .mcu_stall(mcu_stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .ext_ram_int(ext_ram_int)
    );

    // synchronous single-port RAM, read data one cycle after address
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // reference model state
    logic [7:0] ref_mem [0:4095];
    bit         exp_int = 1'b0;
    logic [7:0] exp_cdin = 8'h00;
    logic [7:0] exp_mdin = 8'h00;
    bit         m_last_cpu = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // apply one completed access to the model
    task automatic mdl(input bit cpu, input bit we, input logic [11:0] a, input logic [7:0] d);
        if (we) begin
            ref_mem[a] = d;
            if (cpu && a == INT) exp_int = 1'b1;
        end else if (cpu) begin
            exp_cdin = ref_mem[a];
        end else begin
            exp_mdin = ref_mem[a];
            if (a == INT) exp_int = 1'b0;
        end
        m_last_cpu = cpu;
    endtask

    // One CPU and/or MCU transaction; MCU may be raised mdly cycles after the CPU.
    task automatic run_txn(input bit ce, input bit cwe, input logic [11:0] ca, input logic [7:0] cd,
                           input bit me, input bit mwe, input logic [11:0] ma, input logic [7:0] md,
                           input int mdly);
        int c_k = -1, m_k = -1, c_n = 0, m_n = 0, we_n = 0, stall_bad = 0;
        int exp_ck = 2, exp_mk = 2, exp_we;
        logic [7:0] c_dat = 8'h00, m_dat = 8'h00;
        bit cpu_first;
        cpu_first = ce && (!me || mdly > 0 || !m_last_cpu);
        if (ce && me) begin
            if (cpu_first) exp_mk = 5; else exp_ck = 5;
        end
        exp_we = int'(ce && cwe) + int'(me && mwe);
        if (cpu_first) begin
            mdl(1'b1, cwe, ca, cd);
            if (me) mdl(1'b0, mwe, ma, md);
        end else begin
            if (me) mdl(1'b0, mwe, ma, md);
            if (ce) mdl(1'b1, cwe, ca, cd);
        end

        @(posedge clk); #1;
        cpu_req = ce; cpu_we = cwe; cpu_addr = ca; cpu_dout = cd;
        mcu_req = me && mdly == 0; mcu_we = mwe; mcu_addr = ma; mcu_dout = md;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_ack) begin c_n++; if (c_k < 0) c_k = k; c_dat = cpu_din; end
            if (mcu_ack) begin m_n++; if (m_k < 0) m_k = k; m_dat = mcu_din; end
            if (ram_we) we_n++;
            if (mcu_req && m_k < 0 && !mcu_stall) stall_bad++;
            @(posedge clk); #1;
            if (c_k >= 0) cpu_req = 1'b0;
            if (m_k >= 0) mcu_req = 1'b0;
            else if (me && k + 1 == mdly) mcu_req = 1'b1;
        end
        chk("cpu_ack_count", c_n, ce ? 1 : 0);
        chk("mcu_ack_count", m_n, me ? 1 : 0);
        if (ce) begin
            chk("cpu_ack_cycle", c_k, exp_ck);
            chk("cpu_din", c_dat, exp_cdin);
        end
        if (me) begin
            chk("mcu_ack_cycle", m_k, exp_mk);
            chk("mcu_din", m_dat, exp_mdin);
            chk("mcu_stall_gap", stall_bad, 0);
        end
        chk("ram_we_pulses", we_n, exp_we);
        chk("ext_ram_int", ext_ram_int, exp_int);
    endtask

    // reset asserted during the ACCESS cycle of an MCU write
    task automatic reset_abort(input logic [11:0] a, input logic [7:0] d);
        int m_n = 0;
        @(posedge clk); #1;
        mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = a; mcu_dout = d;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_before", ram_we, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("abort_ram_we", ram_we, 1'b0);
        chk("abort_ram_addr", ram_addr, 12'h000);
        chk("abort_ram_wdata", ram_wdata, 8'h00);
        chk("abort_mcu_ack", mcu_ack, 1'b0);
        chk("abort_int", ext_ram_int, 1'b0);
        chk("abort_cpu_din", cpu_din, 8'h00);
        mcu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mcu_ack) m_n++;
        end
        chk("abort_no_ack", m_n, 0);
        exp_int = 1'b0; exp_cdin = 8'h00; exp_mdin = 8'h00; m_last_cpu = 1'b0;
    endtask

`ifdef CPU_POSTED_WRITE_EN
    // CPU write posted while the MCU owns the RAM, then an ordered CPU read
    task automatic posted_test();
        int cw_k = -1, cr_k = -1, c_n = 0, m_k = -1, phase = 0;
        logic [7:0] rd = 8'h00;
        mdl(1'b0, 1'b0, 12'h200, 8'h00);
        mdl(1'b1, 1'b1, 12'h010, 8'hAA);
        mdl(1'b1, 1'b0, 12'h010, 8'h00);
        @(posedge clk); #1;
        mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 12'h200;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                c_n++;
                if (phase == 1) cw_k = k;
                else if (phase == 2) begin cr_k = k; rd = cpu_din; end
            end
            if (mcu_ack && m_k < 0) m_k = k;
            @(posedge clk); #1;
            if (m_k >= 0) mcu_req = 1'b0;
            if (k == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_dout = 8'hAA; phase = 1;
            end else if (phase == 1 && cw_k >= 0) begin
                cpu_we = 1'b0; phase = 2;
            end else if (phase == 2 && cr_k >= 0) begin
                cpu_req = 1'b0; phase = 3;
            end
        end
        chk("post_mcu_ack_cycle", m_k, 2);
        chk("post_wr_ack_cycle", cw_k, 2);
        chk("post_rd_ack_cycle", cr_k, 8);
        chk("post_rd_data", rd, 8'hAA);
        chk("post_cpu_ack_count", c_n, 2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit allow_cpu_wr;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
`ifdef CPU_POSTED_WRITE_EN
        allow_cpu_wr = 1'b0;
`else
        allow_cpu_wr = 1'b1;
`endif
        #23;
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 12'h000);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_mcu_ack", mcu_ack, 1'b0);
        chk("rst_int", ext_ram_int, 1'b0);
        chk("rst_mcu_din", mcu_din, 8'h00);
        @(negedge clk);
        reset = 1'b0;

`ifdef CPU_POSTED_WRITE_EN
        posted_test();
        run_txn(1, 0, 12'h010, 8'h00, 1, 0, 12'h010, 8'h00, 0);
`else
        run_txn(1, 1, 12'h123, 8'h5A, 0, 0, 12'h000, 8'h00, 0);
        run_txn(1, 0, 12'h123, 8'h00, 0, 0, 12'h000, 8'h00, 0);
        run_txn(1, 0, 12'h123, 8'h00, 1, 0, 12'h123, 8'h00, 0);
        run_txn(1, 0, 12'h123, 8'h00, 1, 0, 12'h123, 8'h00, 0);
        run_txn(1, 1, 12'h040, 8'h3C, 1, 0, 12'h123, 8'h00, 1);
        run_txn(1, 1, INT,     8'h01, 0, 0, 12'h000, 8'h00, 0);
        run_txn(0, 0, 12'h000, 8'h00, 1, 1, INT,     8'h07, 0);
        run_txn(1, 0, INT,     8'h00, 0, 0, 12'h000, 8'h00, 0);
        run_txn(0, 0, 12'h000, 8'h00, 1, 0, INT,     8'h00, 0);
        run_txn(0, 0, 12'h000, 8'h00, 1, 1, INT,     8'h22, 0);
`endif
        reset_abort(12'h050, 8'h99);
        run_txn(0, 0, 12'h000, 8'h00, 1, 0, 12'h050, 8'h00, 0);

        for (int n = 0; n < 60; n++) begin
            int mode, ci, mi, dly;
            bit cwe, mwe;
            logic [11:0] ca, ma;
            mode = $urandom_range(0, 2);
            ci = $urandom_range(0, 4);
            mi = $urandom_range(0, 4);
            ca = (ci == 4) ? INT : 12'h120 + 12'(ci);
            ma = (mi == 4) ? INT : 12'h120 + 12'(mi);
            cwe = allow_cpu_wr && ($urandom_range(0, 1) == 1);
            mwe = $urandom_range(0, 1) == 1;
            dly = (mode == 2) ? $urandom_range(0, 1) : 0;
            run_txn(mode != 1, cwe, ca, 8'($urandom), mode != 0, mwe, ma, 8'($urandom), dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
